// File: rtl/gru_seq_driver_pkg.sv
// Shared definitions for the GRU sequencer: config address map and FSM state type.
package gru_seq_driver_pkg;

  localparam int unsigned NUM_WB = 9;

  localparam logic [3:0] ADDR_BH     = 4'd8;
  localparam logic [3:0] ADDR_HSTATE = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  function automatic logic cfg_addr_ok(input logic [3:0] addr);
    return addr <= ADDR_HSTATE;
  endfunction

endpackage

// File: rtl/gru_wb_regfile.sv
// Nine-entry weight/bias register file; entry 0 (Wz) lands in the LSBs of wb.
import gru_seq_driver_pkg::*;

module gru_wb_regfile #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [3:0]                   addr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [NUM_WB*DATA_WIDTH-1:0] wb
);

  logic [NUM_WB-1:0][DATA_WIDTH-1:0] regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_WB; i++) begin
        if (we && addr == 4'(i)) regs[i] <= wdata;
      end
    end
  end

  assign wb = regs;

endmodule

// File: rtl/gru_seq_driver.sv
// Step sequencer for the combinational GRU cell: holds weights and hidden state, paces each step.
// Optional build macro GRU_SEQ_PERF_CNT_EN adds the perf_steps handshake counter port.
import gru_seq_driver_pkg::*;

module gru_seq_driver #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FRACT_WIDTH = 5,
  parameter int unsigned CELL_LAT    = 2,
  parameter int unsigned SEQ_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [3:0]                   cfg_addr,
  input  logic [DATA_WIDTH-1:0]        cfg_wdata,
  output logic                         cfg_err,
  input  logic                         x_valid,
  input  logic [DATA_WIDTH-1:0]        x_data,
  input  logic                         x_last,
  output logic                         x_ready,
  output logic [DATA_WIDTH-1:0]        cell_x,
  output logic [DATA_WIDTH-1:0]        cell_h_in,
  output logic [NUM_WB*DATA_WIDTH-1:0] cell_wb,
  input  logic [DATA_WIDTH-1:0]        cell_h_out,
  output logic                         h_valid,
  output logic [DATA_WIDTH-1:0]        h_data,
  output logic                         h_last,
  input  logic                         h_ready,
  output logic                         busy,
  output logic [SEQ_W-1:0]             seq_count
`ifdef GRU_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_steps
`endif
);

  if (CELL_LAT < 1 || CELL_LAT > 15 || FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_params
    $error("gru_seq_driver: illegal parameter combination");
  end

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic [DATA_WIDTH-1:0]   x_reg;
  logic [DATA_WIDTH-1:0]   h_state;
  logic                    last_reg;
  logic                    cfg_ok;
  logic                    x_hs;
  logic                    h_hs;
  logic                    cnt_done;

  assign cfg_ok   = cfg_we && (state == ST_IDLE) && cfg_addr_ok(cfg_addr);
  assign x_hs     = x_valid && (state == ST_IDLE);
  assign h_hs     = h_ready && (state == ST_OUT);
  assign cnt_done = (state == ST_WAIT) && (cnt == 4'd1);

  assign x_ready   = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign h_valid   = (state == ST_OUT);
  assign h_last    = (state == ST_OUT) && last_reg;
  assign cell_x    = x_reg;
  assign cell_h_in = h_state;

  gru_wb_regfile #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wb_regfile (
    .clk  (clk),
    .rst  (rst),
    .we   (cfg_ok && cfg_addr <= ADDR_BH),
    .addr (cfg_addr),
    .wdata(cfg_wdata),
    .wb   (cell_wb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (x_hs)     state_nxt = ST_WAIT;
      ST_WAIT: if (cnt_done) state_nxt = ST_OUT;
      ST_OUT:  if (h_hs)     state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      x_reg     <= '0;
      last_reg  <= 1'b0;
      h_state   <= '0;
      h_data    <= '0;
      cfg_err   <= 1'b0;
      seq_count <= '0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;

      if (x_hs) begin
        x_reg    <= x_data;
        last_reg <= x_last;
        cnt      <= 4'(CELL_LAT);
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (cnt_done) h_data <= cell_h_out;

      // A preload only happens in IDLE, so it can never collide with capture or the end-of-sequence clear.
      if (cfg_ok && cfg_addr == ADDR_HSTATE) h_state <= cfg_wdata;
      else if (cnt_done)                     h_state <= cell_h_out;
      else if (h_hs && last_reg)             h_state <= '0;

      if (h_hs) begin
        if (last_reg)              seq_count <= '0;
        else if (seq_count != '1)  seq_count <= seq_count + 1'b1;
      end
    end
  end

`ifdef GRU_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       perf_steps <= '0;
    else if (h_hs) perf_steps <= perf_steps + 32'd1;
  end
`endif

endmodule

// File: tb/tb_gru_seq_driver.sv
// Randomised bench for gru_seq_driver against a time-based transaction model, plus directed literal checks.
module tb_gru_seq_driver;

  localparam int unsigned DW  = 8;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          cfg_err;
  logic          x_valid = 1'b0;
  logic [DW-1:0] x_data = '0;
  logic          x_last = 1'b0;
  logic          x_ready;
  logic [DW-1:0] cell_x, cell_h_in, cell_h_out;
  logic [9*DW-1:0] cell_wb;
  logic          h_valid;
  logic [DW-1:0] h_data;
  logic          h_last;
  logic          h_ready = 1'b0;
  logic          busy;
  logic [7:0]    seq_count;
`ifdef GRU_SEQ_PERF_CNT_EN
  logic [31:0]   perf_steps;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Stub cell: h_out = X + h_in, 8-bit wrap.
  assign cell_h_out = cell_x + cell_h_in;

  gru_seq_driver #(
    .DATA_WIDTH (DW),
    .FRACT_WIDTH(5),
    .CELL_LAT   (LAT),
    .SEQ_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err),
    .x_valid   (x_valid),
    .x_data    (x_data),
    .x_last    (x_last),
    .x_ready   (x_ready),
    .cell_x    (cell_x),
    .cell_h_in (cell_h_in),
    .cell_wb   (cell_wb),
    .cell_h_out(cell_h_out),
    .h_valid   (h_valid),
    .h_data    (h_data),
    .h_last    (h_last),
    .h_ready   (h_ready),
    .busy      (busy),
    .seq_count (seq_count)
`ifdef GRU_SEQ_PERF_CNT_EN
    ,
    .perf_steps(perf_steps)
`endif
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [7:0] m_wb [9];
  logic [7:0] m_hs = '0, m_x = '0, m_hd = '0, m_seq = '0;
  bit         m_last = 0, m_pend = 0, m_pres = 0, m_err = 0;
  int         m_acc = 0, cyc = 0;
  logic [31:0] m_perf = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) m_wb[i] = '0;
      m_hs = '0; m_x = '0; m_hd = '0; m_seq = '0; m_last = 0;
      m_pend = 0; m_pres = 0; m_err = 0; m_perf = '0;
    end else begin
      bit idle;
      idle  = !m_pend;
      m_err = cfg_we && !(idle && cfg_addr <= 4'd9);
      if (cfg_we && idle && cfg_addr <= 4'd9) begin
        if (cfg_addr == 4'd9) m_hs = cfg_wdata;
        else                  m_wb[cfg_addr] = cfg_wdata;
      end
      if (idle && x_valid) begin
        m_pend = 1; m_acc = cyc; m_x = x_data; m_last = x_last;
      end else if (m_pend && !m_pres && cyc == m_acc + LAT) begin
        m_hd = m_x + m_hs; m_hs = m_hd; m_pres = 1;
      end else if (m_pres && h_ready) begin
        m_pend = 0; m_pres = 0; m_perf = m_perf + 1;
        if (m_last) begin m_hs = '0; m_seq = '0; end
        else if (m_seq != 8'hFF) m_seq = m_seq + 1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [71:0] wbx;
    for (int i = 0; i < 9; i++) wbx[i*8 +: 8] = m_wb[i];
    chk("x_ready",   x_ready,   !m_pend);
    chk("busy",      busy,      m_pend);
    chk("h_valid",   h_valid,   m_pres);
    chk("h_last",    h_last,    m_pres && m_last);
    chk("h_data",    h_data,    m_hd);
    chk("cell_x",    cell_x,    m_x);
    chk("cell_h_in", cell_h_in, m_hs);
    chk("cell_wb",   cell_wb,   wbx);
    chk("cfg_err",   cfg_err,   m_err);
    chk("seq_count", seq_count, m_seq);
`ifdef GRU_SEQ_PERF_CNT_EN
    chk("perf_steps", perf_steps, m_perf);
`endif
  end

  // ---------------- directed helpers ----------------
  task automatic accept(input logic [7:0] xd, input bit xl);
    @(negedge clk); x_valid = 1; x_data = xd; x_last = xl;
    @(negedge clk); x_valid = 0;
  endtask

  // Entered at the negedge right after the accept edge; lat counts edges from accept to first visible h_valid.
  task automatic collect(output logic [7:0] hd, output bit hl, output int lat);
    lat = 1;
    while (!h_valid && lat < 64) begin @(negedge clk); lat++; end
    if (lat >= 64) chk("h_valid_timeout", 1'b0, 1'b1);
    hd = h_data; hl = h_last;
    h_ready = 1;
    @(negedge clk); h_ready = 0;
  endtask

  initial begin
    logic [7:0]  hd;
    logic [71:0] wbv;
    bit          hl;
    int          lat, guard;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_x_ready", x_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cell_wb", cell_wb, 72'h0);
    chk("rst_seq_count", seq_count, 8'h00);

    // Latency and first result
    accept(8'h20, 1); collect(hd, hl, lat);
    chk("lat_edges", lat, LAT + 1);
    chk("lat_h_data", hd, 8'h20);
    chk("lat_h_last", hl, 1'b1);

    // Recurrence across a three-step sequence
    accept(8'h10, 0); collect(hd, hl, lat); chk("rec1", {hl, hd}, {1'b0, 8'h10});
    accept(8'h10, 0); collect(hd, hl, lat); chk("rec2", {hl, hd}, {1'b0, 8'h20});
    accept(8'h10, 1); collect(hd, hl, lat); chk("rec3", {hl, hd}, {1'b1, 8'h30});
    chk("rec_h_cleared", cell_h_in, 8'h00);
    chk("rec_seq_cleared", seq_count, 8'h00);

    // Config writes: accepted in IDLE, rejected for bad address or while busy
    @(negedge clk); cfg_we = 1; cfg_addr = 4'd3; cfg_wdata = 8'hA5;
    @(negedge clk); cfg_we = 0;
    wbv = cell_wb;
    chk("cfg_uz", wbv[31:24], 8'hA5);
    chk("cfg_ok_err", cfg_err, 1'b0);
    @(negedge clk); cfg_we = 1; cfg_addr = 4'd12; cfg_wdata = 8'hFF;
    @(negedge clk); cfg_we = 0;
    chk("cfg_bad_addr_err", cfg_err, 1'b1);
    accept(8'h01, 1);
    cfg_we = 1; cfg_addr = 4'd3; cfg_wdata = 8'h5A;
    @(negedge clk); cfg_we = 0;
    chk("cfg_busy_err", cfg_err, 1'b1);
    wbv = cell_wb;
    chk("cfg_busy_nochange", wbv[31:24], 8'hA5);
    collect(hd, hl, lat); chk("cfg_step_h", hd, 8'h01);

    // Preload racing an x handshake
    @(negedge clk); x_valid = 1; x_data = 8'h05; x_last = 1;
    cfg_we = 1; cfg_addr = 4'd9; cfg_wdata = 8'h40;
    @(negedge clk); x_valid = 0; cfg_we = 0;
    chk("preload_h_in", cell_h_in, 8'h40);
    collect(hd, hl, lat); chk("preload_h", hd, 8'h45);

    // Back-pressure with a second sample already offered
    accept(8'h11, 1);
    guard = 0;
    while (!h_valid && guard < 64) begin @(negedge clk); guard++; end
    x_valid = 1; x_data = 8'h22; x_last = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", h_valid, 1'b1);
      chk("bp_data", h_data, 8'h11);
      chk("bp_x_ready", x_ready, 1'b0);
    end
    h_ready = 1;
    @(negedge clk); h_ready = 0;
    @(negedge clk); x_valid = 0;
    collect(hd, hl, lat); chk("bp_second", hd, 8'h22);

    // Reset in the middle of a WAIT window
    @(negedge clk); cfg_we = 1; cfg_addr = 4'd9; cfg_wdata = 8'h7F;
    @(negedge clk); cfg_we = 0;
    accept(8'h33, 0);
    #2 rst = 1;
    #1;
    chk("mid_rst_h_valid", h_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_x_ready", x_ready, 1'b1);
    chk("mid_rst_cell_wb", cell_wb, 72'h0);
    chk("mid_rst_h_state", cell_h_in, 8'h00);
    @(negedge clk); rst = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_h_valid", h_valid, 1'b0);

    // Long sequence without x_last to drive seq_count into saturation
    x_valid = 1; h_ready = 1; x_last = 0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk); x_data = 8'($urandom);
    end
    chk("seq_saturated", seq_count, 8'hFF);

    // Fully random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      x_valid   = 1'($urandom_range(0, 1));
      x_data    = 8'($urandom);
      x_last    = ($urandom_range(0, 3) == 0);
      h_ready   = 1'($urandom_range(0, 1));
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = 4'($urandom);
      cfg_wdata = 8'($urandom);
    end
    @(negedge clk); x_valid = 0; cfg_we = 0; h_ready = 1;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
